// File: rtl/host_sched_pkg.sv
// host_sched_pkg: shared FSM states, scheduling modes and queue-id sizing
package host_sched_pkg;
    typedef enum logic [1:0] {
        IDLE_S              = 2'd0,
        PRIORITY_SCHEDULE_S = 2'd1,
        GET_BUFID_S         = 2'd2
    } hos_state_t;
    localparam logic MODE_STRICT = 1'b0;
    localparam logic MODE_RR     = 1'b1;
    function automatic int qid_w(input int nq);
        return $clog2(nq + 1);
    endfunction
endpackage

// File: rtl/host_rr_arbiter.sv
// host_rr_arbiter: picks one requesting queue, lowest index (strict) or first from ptr with wrap (rr)
module host_rr_arbiter
    import host_sched_pkg::*;
#(
    parameter int NQ = 4
) (
    input  logic [NQ-1:0]         req,
    input  logic [$clog2(NQ)-1:0] ptr,
    input  logic                  mode,
    output logic [NQ-1:0]         grant,
    output logic [$clog2(NQ)-1:0] idx
);
    localparam int PW = $clog2(NQ);
    int   j;
    logic found;
    // scan queues in priority order and keep the first one that is requesting
    always_comb begin
        j = 0;
        found = 1'b0;
        idx = '0;
        for (int i = 0; i < NQ; i++) begin
            j = (mode == MODE_STRICT) ? i : (int'(ptr) + i) % NQ;
            if (!found && req[j]) begin
                found = 1'b1;
                idx = PW'(j);
            end
        end
        grant = found ? (NQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/host_queue_scheduler.sv
// host_queue_scheduler: forwards TS descriptors first, then non-TS queue descriptors by strict or rr choice
module host_queue_scheduler
    import host_sched_pkg::*;
#(
    parameter int DESC_W = 13,
    parameter int NQ     = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [DESC_W-1:0]        iv_ts_descriptor,
    input  logic                     i_ts_descriptor_wr,
    output logic                     o_ts_descriptor_scheduled,
    input  logic [NQ-1:0]            iv_fifo_empty,
    output logic [NQ-1:0]            ov_nts_descriptor_rd,
    input  logic [NQ*DESC_W-1:0]     iv_nts_descriptor,
    input  logic                     i_sched_mode,
    input  logic                     i_host_outport_free,
    output logic [DESC_W-1:0]        ov_descriptor,
    output logic                     o_descriptor_wr,
    output logic [qid_w(NQ)-1:0]     ov_queue_id,
    output logic [CNT_W-1:0]         ov_ts_cnt,
    output logic [CNT_W-1:0]         ov_nts_cnt,
    output logic [1:0]               ov_hos_state
);
    localparam int PW = $clog2(NQ);
    localparam int QW = qid_w(NQ);
    hos_state_t    state;
    logic          init;
    logic [PW-1:0] ptr, q_lat, idx;
    logic [NQ-1:0] req, grant;
    assign req = ~iv_fifo_empty;
    assign ov_hos_state = state;
    host_rr_arbiter #(.NQ(NQ)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .mode  (i_sched_mode),
        .grant (grant),
        .idx   (idx)
    );
    // scheduler FSM with registered pulses, descriptor output and statistics
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE_S;
            init <= 1'b1;
            ptr <= '0;
            q_lat <= '0;
            o_ts_descriptor_scheduled <= 1'b0;
            ov_nts_descriptor_rd <= '0;
            ov_descriptor <= '0;
            o_descriptor_wr <= 1'b0;
            ov_queue_id <= '0;
            ov_ts_cnt <= '0;
            ov_nts_cnt <= '0;
        end else begin
            o_ts_descriptor_scheduled <= 1'b0;
            o_descriptor_wr <= 1'b0;
            ov_nts_descriptor_rd <= '0;
            case (state)
                IDLE_S: begin
                    ov_descriptor <= '0;
                    ov_queue_id <= '0;
                    init <= 1'b0;
                    if (i_host_outport_free || init) state <= PRIORITY_SCHEDULE_S;
                end
                PRIORITY_SCHEDULE_S: begin
                    if (i_ts_descriptor_wr) begin
                        ov_descriptor <= iv_ts_descriptor;
                        o_descriptor_wr <= 1'b1;
                        o_ts_descriptor_scheduled <= 1'b1;
                        ov_queue_id <= QW'(NQ);
                        ov_ts_cnt <= ov_ts_cnt + 1'b1;
                        state <= IDLE_S;
                    end else if (|req) begin
                        ov_nts_descriptor_rd <= grant;
                        q_lat <= idx;
                        if (i_sched_mode == MODE_RR) ptr <= (idx == PW'(NQ - 1)) ? '0 : idx + 1'b1;
                        state <= GET_BUFID_S;
                    end
                end
                GET_BUFID_S: begin
                    ov_descriptor <= iv_nts_descriptor[int'(q_lat)*DESC_W +: DESC_W];
                    o_descriptor_wr <= 1'b1;
                    ov_queue_id <= QW'(q_lat);
                    ov_nts_cnt <= ov_nts_cnt + 1'b1;
                    state <= IDLE_S;
                end
                default: begin
                    ov_descriptor <= '0;
                    ov_queue_id <= '0;
                    state <= IDLE_S;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_host_queue_scheduler.sv
// tb_host_queue_scheduler: directed checks of init, TS priority, strict, rr, reset abort and counter wrap
module tb_host_queue_scheduler;
    localparam int DESC_W = 13;
    localparam int NQ = 4;
    localparam int CNT_W = 4;
    localparam int QW = 3;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic [DESC_W-1:0] iv_ts_descriptor = '0;
    logic i_ts_descriptor_wr = 1'b0;
    logic o_ts_descriptor_scheduled;
    logic [NQ-1:0] iv_fifo_empty = '1;
    logic [NQ-1:0] ov_nts_descriptor_rd;
    logic [NQ*DESC_W-1:0] iv_nts_descriptor;
    logic i_sched_mode = 1'b0;
    logic i_host_outport_free = 1'b0;
    logic [DESC_W-1:0] ov_descriptor;
    logic o_descriptor_wr;
    logic [QW-1:0] ov_queue_id;
    logic [CNT_W-1:0] ov_ts_cnt, ov_nts_cnt;
    logic [1:0] ov_hos_state;
    logic [DESC_W-1:0] bufid [NQ] = '{13'h100, 13'h011, 13'h222, 13'h033};
    int checks = 0;
    int failures = 0;
    assign iv_nts_descriptor = {bufid[3], bufid[2], bufid[1], bufid[0]};
    always #5 i_clk = ~i_clk;
    host_queue_scheduler #(.DESC_W(DESC_W), .NQ(NQ), .CNT_W(CNT_W)) dut (
        .i_clk                     (i_clk),
        .i_rst                     (i_rst),
        .iv_ts_descriptor          (iv_ts_descriptor),
        .i_ts_descriptor_wr        (i_ts_descriptor_wr),
        .o_ts_descriptor_scheduled (o_ts_descriptor_scheduled),
        .iv_fifo_empty             (iv_fifo_empty),
        .ov_nts_descriptor_rd      (ov_nts_descriptor_rd),
        .iv_nts_descriptor         (iv_nts_descriptor),
        .i_sched_mode              (i_sched_mode),
        .i_host_outport_free       (i_host_outport_free),
        .ov_descriptor             (ov_descriptor),
        .o_descriptor_wr           (o_descriptor_wr),
        .ov_queue_id               (ov_queue_id),
        .ov_ts_cnt                 (ov_ts_cnt),
        .ov_nts_cnt                (ov_nts_cnt),
        .ov_hos_state              (ov_hos_state)
    );
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask
    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        checks++;
        if (ov_hos_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", ov_hos_state); end
        checks++;
        if ({o_descriptor_wr, o_ts_descriptor_scheduled, ov_nts_descriptor_rd} !== 6'b0) begin
            failures++; $display("FAIL reset_pulses got=%b exp=000000", {o_descriptor_wr, o_ts_descriptor_scheduled, ov_nts_descriptor_rd});
        end
        checks++;
        if ({ov_descriptor, ov_queue_id} !== '0) begin failures++; $display("FAIL reset_desc got=%h/%0d exp=0/0", ov_descriptor, ov_queue_id); end
        checks++;
        if ({ov_ts_cnt, ov_nts_cnt} !== 8'h00) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", ov_ts_cnt, ov_nts_cnt); end
        i_rst = 1'b0;
    endtask
    task automatic test_init();
        int wr_seen = 0;
        tick();
        checks++;
        if (ov_hos_state !== 2'd1) begin failures++; $display("FAIL init_to_sched got=%0d exp=1", ov_hos_state); end
        repeat (4) begin
            tick();
            wr_seen += int'(o_descriptor_wr) + int'(|ov_nts_descriptor_rd);
        end
        checks++;
        if (ov_hos_state !== 2'd1) begin failures++; $display("FAIL init_hold got=%0d exp=1", ov_hos_state); end
        checks++;
        if (wr_seen !== 0) begin failures++; $display("FAIL init_no_wr got=%0d exp=0", wr_seen); end
    endtask
    task automatic test_ts_vs_nts();
        iv_ts_descriptor = 13'h0A5;
        i_ts_descriptor_wr = 1'b1;
        iv_fifo_empty = 4'b1101;
        tick();
        checks++;
        if ({o_descriptor_wr, o_ts_descriptor_scheduled, ov_nts_descriptor_rd} !== 6'b110000) begin
            failures++; $display("FAIL ts_pulses got=%b exp=110000", {o_descriptor_wr, o_ts_descriptor_scheduled, ov_nts_descriptor_rd});
        end
        checks++;
        if ({ov_descriptor, ov_queue_id} !== {13'h0A5, 3'd4}) begin failures++; $display("FAIL ts_desc got=%h/%0d exp=0a5/4", ov_descriptor, ov_queue_id); end
        checks++;
        if (ov_ts_cnt !== 4'd1 || ov_hos_state !== 2'd0) begin failures++; $display("FAIL ts_cnt_state got=%0d/%0d exp=1/0", ov_ts_cnt, ov_hos_state); end
        i_ts_descriptor_wr = 1'b0;
        tick();
        checks++;
        if ({o_descriptor_wr, ov_descriptor, ov_hos_state} !== {1'b0, 13'h0, 2'd0}) begin
            failures++; $display("FAIL ts_idle got=%b/%h/%0d exp=0/0/0", o_descriptor_wr, ov_descriptor, ov_hos_state);
        end
    endtask
    task automatic test_strict();
        i_sched_mode = 1'b0;
        iv_fifo_empty = 4'b0101;
        i_host_outport_free = 1'b1;
        tick();
        checks++;
        if (ov_hos_state !== 2'd1) begin failures++; $display("FAIL strict_sched got=%0d exp=1", ov_hos_state); end
        tick();
        checks++;
        if (ov_nts_descriptor_rd !== 4'b0010 || o_descriptor_wr !== 1'b0) begin failures++; $display("FAIL strict_rd1 got=%b wr=%b exp=0010 wr=0", ov_nts_descriptor_rd, o_descriptor_wr); end
        iv_fifo_empty = 4'b0111;
        tick();
        checks++;
        if ({o_descriptor_wr, ov_descriptor, ov_queue_id, ov_nts_descriptor_rd} !== {1'b1, 13'h011, 3'd1, 4'b0}) begin
            failures++; $display("FAIL strict_out1 got=%b/%h/%0d/%b exp=1/011/1/0000", o_descriptor_wr, ov_descriptor, ov_queue_id, ov_nts_descriptor_rd);
        end
        tick();
        tick();
        checks++;
        if (ov_nts_descriptor_rd !== 4'b1000) begin failures++; $display("FAIL strict_rd3 got=%b exp=1000", ov_nts_descriptor_rd); end
        tick();
        checks++;
        if ({o_descriptor_wr, ov_descriptor, ov_queue_id, ov_nts_cnt} !== {1'b1, 13'h033, 3'd3, 4'd2}) begin
            failures++; $display("FAIL strict_out3 got=%b/%h/%0d/%0d exp=1/033/3/2", o_descriptor_wr, ov_descriptor, ov_queue_id, ov_nts_cnt);
        end
        i_host_outport_free = 1'b0;
        iv_fifo_empty = '1;
    endtask
    task automatic test_rr();
        int order [6] = '{0, 1, 4, 2, 3, 0};
        i_sched_mode = 1'b1;
        iv_fifo_empty = 4'b0000;
        i_host_outport_free = 1'b1;
        foreach (order[k]) begin
            if (order[k] == NQ) begin
                iv_ts_descriptor = 13'h1AB;
                i_ts_descriptor_wr = 1'b1;
            end
            tick();
            tick();
            if (order[k] == NQ) begin
                checks++;
                if ({o_ts_descriptor_scheduled, o_descriptor_wr, ov_queue_id, ov_descriptor, ov_nts_descriptor_rd} !== {1'b1, 1'b1, 3'd4, 13'h1AB, 4'b0}) begin
                    failures++; $display("FAIL rr_ts got=%b/%b/%0d/%h/%b exp=1/1/4/1ab/0000", o_ts_descriptor_scheduled, o_descriptor_wr, ov_queue_id, ov_descriptor, ov_nts_descriptor_rd);
                end
                i_ts_descriptor_wr = 1'b0;
            end else begin
                checks++;
                if (ov_nts_descriptor_rd !== 4'(1 << order[k])) begin failures++; $display("FAIL rr_rd step=%0d got=%b exp=%b", k, ov_nts_descriptor_rd, 4'(1 << order[k])); end
                tick();
                checks++;
                if ({o_descriptor_wr, ov_queue_id, ov_descriptor} !== {1'b1, QW'(order[k]), bufid[order[k]]}) begin
                    failures++; $display("FAIL rr_out step=%0d got=%b/%0d/%h exp=1/%0d/%h", k, o_descriptor_wr, ov_queue_id, ov_descriptor, order[k], bufid[order[k]]);
                end
            end
        end
        checks++;
        if ({ov_ts_cnt, ov_nts_cnt} !== {4'd2, 4'd7}) begin failures++; $display("FAIL rr_cnt got=%0d/%0d exp=2/7", ov_ts_cnt, ov_nts_cnt); end
        i_host_outport_free = 1'b0;
    endtask
    task automatic test_reset_get();
        i_host_outport_free = 1'b1;
        tick();
        tick();
        checks++;
        if (ov_nts_descriptor_rd !== 4'b0010 || ov_hos_state !== 2'd2) begin failures++; $display("FAIL rst_get_pre got=%b/%0d exp=0010/2", ov_nts_descriptor_rd, ov_hos_state); end
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checks++;
        if ({o_descriptor_wr, ov_descriptor, ov_ts_cnt, ov_nts_cnt, ov_hos_state} !== '0) begin
            failures++; $display("FAIL rst_get_clear got=%b/%h/%0d/%0d/%0d exp=0/0/0/0/0", o_descriptor_wr, ov_descriptor, ov_ts_cnt, ov_nts_cnt, ov_hos_state);
        end
        tick();
        checks++;
        if (o_descriptor_wr !== 1'b0 || ov_hos_state !== 2'd1) begin failures++; $display("FAIL rst_get_idle got=%b/%0d exp=0/1", o_descriptor_wr, ov_hos_state); end
        tick();
        checks++;
        if (ov_nts_descriptor_rd !== 4'b0001 || o_descriptor_wr !== 1'b0) begin failures++; $display("FAIL rst_get_rd got=%b wr=%b exp=0001 wr=0", ov_nts_descriptor_rd, o_descriptor_wr); end
        tick();
        checks++;
        if ({o_descriptor_wr, ov_queue_id, ov_descriptor, ov_nts_cnt} !== {1'b1, 3'd0, 13'h100, 4'd1}) begin
            failures++; $display("FAIL rst_get_out got=%b/%0d/%h/%0d exp=1/0/100/1", o_descriptor_wr, ov_queue_id, ov_descriptor, ov_nts_cnt);
        end
        i_host_outport_free = 1'b0;
        iv_fifo_empty = '1;
    endtask
    task automatic test_cnt_wrap();
        int n = 0;
        int cyc = 0;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        iv_fifo_empty = '1;
        i_host_outport_free = 1'b1;
        iv_ts_descriptor = 13'h055;
        i_ts_descriptor_wr = 1'b1;
        while (n < 17 && cyc < 100) begin
            tick();
            cyc++;
            if (o_ts_descriptor_scheduled) begin
                n++;
                if (n == 16) begin
                    checks++;
                    if (ov_ts_cnt !== 4'd0) begin failures++; $display("FAIL wrap_16 got=%0d exp=0", ov_ts_cnt); end
                end
            end
        end
        i_ts_descriptor_wr = 1'b0;
        checks++;
        if (n !== 17) begin failures++; $display("FAIL wrap_grants got=%0d exp=17", n); end
        checks++;
        if ({ov_ts_cnt, ov_nts_cnt} !== {4'd1, 4'd0}) begin failures++; $display("FAIL wrap_17 got=%0d/%0d exp=1/0", ov_ts_cnt, ov_nts_cnt); end
    endtask
    initial begin
        test_reset();
        test_init();
        test_ts_vs_nts();
        test_strict();
        test_rr();
        test_reset_get();
        test_cnt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/host_queue_scheduler.md
HOST_QUEUE_SCHEDULER -- requirements
Module: host_queue_scheduler

Interface
REQ-001 SHALL have parameter DESC_W, default 13, descriptor (bufid) width.
REQ-002 SHALL have parameter NQ, default 4, number of non-TS queues (legal 2..8).
REQ-003 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-004 SHALL have one clock; reset is synchronous and active-high: i_clk  in  1  clock; i_rst  in  1  synchronous active-high reset.
REQ-005 SHALL have iv_ts_descriptor  in  DESC_W  TS bufid; i_ts_descriptor_wr  in  1  TS bufid valid (level, held until scheduled); o_ts_descriptor_scheduled  out  1  one-cycle TS accept pulse.
REQ-006 SHALL have iv_fifo_empty  in  NQ  per-queue empty; ov_nts_descriptor_rd  out  NQ  per-queue one-hot read pulse; iv_nts_descriptor  in  NQ*DESC_W  queue q data in bits [q*DESC_W +: DESC_W], valid one cycle after rd.
REQ-007 SHALL have i_sched_mode  in  1  0=strict priority (queue 0 highest), 1=round-robin among non-TS queues.
REQ-008 SHALL have i_host_outport_free  in  1  output port can accept next descriptor.
REQ-009 SHALL have ov_descriptor  out  DESC_W; o_descriptor_wr  out  1  one-cycle valid; ov_queue_id  out  clog2(NQ+1)  source (NQ = TS), valid with o_descriptor_wr.
REQ-010 SHALL have ov_ts_cnt, ov_nts_cnt  out  CNT_W  scheduled-descriptor counters; ov_hos_state  out  2  current FSM state.

Function
REQ-011 SHALL implement FSM IDLE_S=0, PRIORITY_SCHEDULE_S=1, GET_BUFID_S=2; undefined encoding -> IDLE_S with all pulses low.
REQ-012 IDLE_S: all pulses low, ov_descriptor=0; go PRIORITY_SCHEDULE_S if i_host_outport_free=1 or init flag=1, else stay; init flag cleared on first IDLE_S cycle.
REQ-013 PRIORITY_SCHEDULE_S with i_ts_descriptor_wr=1: next cycle ov_descriptor=iv_ts_descriptor, o_descriptor_wr=1, o_ts_descriptor_scheduled=1, ov_queue_id=NQ; go IDLE_S.
REQ-014 PRIORITY_SCHEDULE_S, no TS, any queue non-empty: pulse ov_nts_descriptor_rd for exactly one selected queue q, latch q; go GET_BUFID_S.
REQ-015 GET_BUFID_S: rd low; next cycle ov_descriptor=iv_nts_descriptor[q], o_descriptor_wr=1, ov_queue_id=q; go IDLE_S.
REQ-016 PRIORITY_SCHEDULE_S with nothing pending: outputs low, stay.
REQ-017 TS SHALL always beat non-TS when both pending in the same cycle.
REQ-018 Strict mode: select lowest-index non-empty queue.
REQ-019 RR mode: select first non-empty queue searching from pointer p upward with wrap NQ-1 -> 0; after grant to q, p <= (q+1) mod NQ; TS grants leave p unchanged.
REQ-020 i_sched_mode SHALL be sampled only in PRIORITY_SCHEDULE_S; a change takes effect at the next decision, p retained.
REQ-021 Read SHALL never be issued to a queue whose empty bit is 1 in the decision cycle.
REQ-022 Latency: TS wr -> o_descriptor_wr 1 cycle; non-TS decision -> rd same-cycle register, o_descriptor_wr 2 cycles after decision.
REQ-023 ov_ts_cnt increments on each TS grant, ov_nts_cnt on each non-TS o_descriptor_wr; both wrap from all-ones to 0.

Reset
REQ-024 On i_rst=1 at posedge: state IDLE_S, init flag 1, p=0, latched q=0, all outputs 0 (including o_ts_descriptor_scheduled and counters).
REQ-025 Reset mid-GET_BUFID_S SHALL discard the pending descriptor; no o_descriptor_wr after release until a new decision.

Structure
REQ-026 Shared package host_sched_pkg SHALL hold state localparams, queue-id width function, mode encodings.
REQ-027 Selection logic SHALL be sub-module host_rr_arbiter (request vector, pointer, mode -> one-hot grant and index).

Verification
REQ-028 Init: release reset, all empty, outport_free=0 -> FSM reaches PRIORITY_SCHEDULE_S once via init flag, no writes.
REQ-029 TS vs NTS: ts_wr=1 bufid 0x0A5, queue 1 non-empty -> ov_descriptor=0x0A5, queue_id=4, scheduled pulse, no rd.
REQ-030 Strict: empty=4'b0101, bufids q1=0x011, q3=0x033 -> rd=4'b0010 first, output 0x011 two cycles after decision.
REQ-031 RR: all queues non-empty, mode=1, outport_free=1 -> grant order 0,1,2,3,0; pointer unchanged across an interleaved TS grant.
REQ-032 Reset asserted in GET_BUFID_S -> no o_descriptor_wr, counters 0, next RR grant from queue 0.
REQ-033 Counter wrap: CNT_W=4, 17 TS grants -> ov_ts_cnt=1.
